he_hssi_kpi_seq: RTL

- Hardware sequencer for the HE-HSSI KPI traffic test.
- Acts as a CSR master into the HE-HSSI register space. It programs the traffic generator, starts the transfer, then polls the traffic monitor until every packet is accounted for.
- Then reads the monitor start/end timestamps and reports pass/fail, packet counts and transfer latency.
- Sits between the test-control logic and the HE-HSSI CSR slave; it replaces software-driven register sequencing for KPI runs.

---
 rtl/he_hssi_kpi_seq.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/he_hssi_kpi_seq.sv
// he_hssi_kpi_seq: hardware sequencer for the HE-HSSI KPI traffic test.
// As CSR master it programs the traffic generator and starts the transfer.
// It then polls the traffic monitor until every packet is accounted for,
// reads the start/end timestamps, and reports pass/fail, counts and latency.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   start, cfg_pkt_len/pattern/num_pkt   run request and per-run configuration
//   csr_req/wr/addr/wdata         CSR request to the HE-HSSI slave (held until ack)
//   csr_ack, csr_rdata            CSR completion and read data
//   busy, done, pass              run status (done is a one-cycle pulse)
//   cfg_err, timeout_err          run rejected (num_pkt==0) / run aborted (timeout)
//   good_cnt, bad_cnt, latency    last monitor counts and end-start timestamp delta
module he_hssi_kpi_seq #(
  parameter logic [31:0] BASE_ADDR   = 32'h0018_0000,
  parameter int unsigned POLL_GAP    = 64,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] cfg_pkt_len,
  input  logic [31:0] cfg_pattern,
  input  logic [31:0] cfg_num_pkt,
  output logic        csr_req,
  output logic        csr_wr,
  output logic [31:0] csr_addr,
  output logic [31:0] csr_wdata,
  input  logic        csr_ack,
  input  logic [31:0] csr_rdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        cfg_err,
  output logic        timeout_err,
  output logic [31:0] good_cnt,
  output logic [31:0] bad_cnt,
  output logic [31:0] latency
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 16;

  localparam logic [DATA_W-1:0] OFF_TG_PKT_LEN      = 32'h0000_E034;
  localparam logic [DATA_W-1:0] OFF_TG_DATA_PATTERN = 32'h0000_E008;
  localparam logic [DATA_W-1:0] OFF_TG_NUM_PKT      = 32'h0000_E000;
  localparam logic [DATA_W-1:0] OFF_TG_START_XFR    = 32'h0000_E00C;
  localparam logic [DATA_W-1:0] OFF_TM_PKT_GOOD     = 32'h0000_E404;
  localparam logic [DATA_W-1:0] OFF_TM_PKT_BAD      = 32'h0000_E408;
  localparam logic [DATA_W-1:0] OFF_TM_START_TS     = 32'h0000_E42C;
  localparam logic [DATA_W-1:0] OFF_TM_END_TS       = 32'h0000_E430;

  typedef enum logic [3:0] {
    S_IDLE, S_WR_LEN, S_WR_PAT, S_WR_NUM, S_WR_START, S_RD_GOOD, S_RD_BAD,
    S_CHECK, S_GAP, S_RD_TS0, S_RD_TS1, S_FIN
  } state_t;

  state_t              state, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   pat_q, pat_d, num_q, num_d, ts0_q, ts0_d;
  logic [DATA_W-1:0]   tcnt, tcnt_d, gap_cnt, gap_d;
  logic                csr_req_d, csr_wr_d, busy_d, done_d, pass_d, cfg_err_d, timeout_err_d;
  logic [DATA_W-1:0]   csr_addr_d, csr_wdata_d, good_d, bad_d, latency_d;
  logic                op_wr;
  logic [DATA_W-1:0]   op_off, op_wdata;
  state_t              op_next;
  logic [DATA_W:0]     sum;

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    len_d         = len_q;
    pat_d         = pat_q;
    num_d         = num_q;
    ts0_d         = ts0_q;
    tcnt_d        = tcnt;
    gap_d         = gap_cnt;
    csr_req_d     = csr_req;
    csr_wr_d      = csr_wr;
    csr_addr_d    = csr_addr;
    csr_wdata_d   = csr_wdata;
    busy_d        = busy;
    done_d        = 1'b0;
    pass_d        = pass;
    cfg_err_d     = cfg_err;
    timeout_err_d = timeout_err;
    good_d        = good_cnt;
    bad_d         = bad_cnt;
    latency_d     = latency;
    op_wr         = 1'b0;
    op_off        = '0;
    op_wdata      = '0;
    op_next       = S_IDLE;
    sum           = {1'b0, good_cnt} + {1'b0, bad_cnt};

    // CSR operation performed by each bus state and where it goes on ack
    case (state)
      S_WR_LEN:   begin op_wr = 1'b1; op_off = OFF_TG_PKT_LEN;      op_wdata = DATA_W'(len_q); op_next = S_WR_PAT;   end
      S_WR_PAT:   begin op_wr = 1'b1; op_off = OFF_TG_DATA_PATTERN; op_wdata = pat_q;         op_next = S_WR_NUM;   end
      S_WR_NUM:   begin op_wr = 1'b1; op_off = OFF_TG_NUM_PKT;      op_wdata = num_q;         op_next = S_WR_START; end
      S_WR_START: begin op_wr = 1'b1; op_off = OFF_TG_START_XFR;    op_wdata = 32'd1;         op_next = S_RD_GOOD;  end
      S_RD_GOOD:  begin op_off = OFF_TM_PKT_GOOD; op_next = S_RD_BAD; end
      S_RD_BAD:   begin op_off = OFF_TM_PKT_BAD;  op_next = S_CHECK;  end
      S_RD_TS0:   begin op_off = OFF_TM_START_TS; op_next = S_RD_TS1; end
      S_RD_TS1:   begin op_off = OFF_TM_END_TS;   op_next = S_FIN;    end
      default:    ;
    endcase

    case (state)
      S_IDLE: begin
        // A start coinciding with the done pulse is dropped
        if (start && !done) begin
          if (cfg_num_pkt == '0) begin
            done_d        = 1'b1;
            cfg_err_d     = 1'b1;
            pass_d        = 1'b0;
            timeout_err_d = 1'b0;
          end else begin
            busy_d        = 1'b1;
            pass_d        = 1'b0;
            cfg_err_d     = 1'b0;
            timeout_err_d = 1'b0;
            good_d        = '0;
            bad_d         = '0;
            latency_d     = '0;
            len_d         = cfg_pkt_len;
            pat_d         = cfg_pattern;
            num_d         = cfg_num_pkt;
            tcnt_d        = '0;
            state_d       = S_WR_LEN;
          end
        end
      end
      S_CHECK: begin
        if (sum >= {1'b0, num_q}) begin
          state_d = S_RD_TS0;
        end else begin
          gap_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == DATA_W'(POLL_GAP - 1)) state_d = S_RD_GOOD;
        else gap_d = gap_cnt + 32'd1;
      end
      S_FIN: begin
        pass_d  = (bad_cnt == '0) && (good_cnt == num_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        // Bus states: raise the request one cycle after entry, hold until ack
        if (!csr_req) begin
          csr_req_d   = 1'b1;
          csr_wr_d    = op_wr;
          csr_addr_d  = BASE_ADDR + op_off;
          csr_wdata_d = op_wdata;
        end else if (csr_ack) begin
          csr_req_d = 1'b0;
          state_d   = op_next;
          case (state)
            S_RD_GOOD: good_d    = csr_rdata;
            S_RD_BAD:  bad_d     = csr_rdata;
            S_RD_TS0:  ts0_d     = csr_rdata;
            S_RD_TS1:  latency_d = csr_rdata - ts0_q;
            default:   ;
          endcase
        end
      end
    endcase

    // Run watchdog: overrides everything, including an ack in the same cycle
    if (busy) begin
      tcnt_d = tcnt + 32'd1;
      if (tcnt + 32'd1 == DATA_W'(TIMEOUT_CYC)) begin
        state_d       = S_IDLE;
        csr_req_d     = 1'b0;
        timeout_err_d = 1'b1;
        pass_d        = 1'b0;
        done_d        = 1'b1;
        busy_d        = 1'b0;
        good_d        = good_cnt;
        bad_d         = bad_cnt;
        latency_d     = latency;
        ts0_d         = ts0_q;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      len_q       <= '0;
      pat_q       <= '0;
      num_q       <= '0;
      ts0_q       <= '0;
      tcnt        <= '0;
      gap_cnt     <= '0;
      csr_req     <= 1'b0;
      csr_wr      <= 1'b0;
      csr_addr    <= '0;
      csr_wdata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      cfg_err     <= 1'b0;
      timeout_err <= 1'b0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      latency     <= '0;
    end else begin
      state       <= state_d;
      len_q       <= len_d;
      pat_q       <= pat_d;
      num_q       <= num_d;
      ts0_q       <= ts0_d;
      tcnt        <= tcnt_d;
      gap_cnt     <= gap_d;
      csr_req     <= csr_req_d;
      csr_wr      <= csr_wr_d;
      csr_addr    <= csr_addr_d;
      csr_wdata   <= csr_wdata_d;
      busy        <= busy_d;
      done        <= done_d;
      pass        <= pass_d;
      cfg_err     <= cfg_err_d;
      timeout_err <= timeout_err_d;
      good_cnt    <= good_d;
      bad_cnt     <= bad_d;
      latency     <= latency_d;
    end
  end

endmodule
